// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer and U/J immediate pre-extraction.
// Define IF_ID_PERF_EN to add the Stall_Cnt / Flush_Cnt performance counters.
module if_id_stage #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [N-1:0] NOP      = 32'h0000_0013
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [N-1:0] In_Inst,
  input  logic [N-1:0] In_PC,
  input  logic         Flush,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [N-1:0] Out_Inst,
  output logic [N-1:0] Out_PC,
  output logic [19:0]  Out_Imm,
  output logic         Out_Imm_Type,
  output logic         Out_Imm_Use
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]  Stall_Cnt,
  output logic [15:0]  Flush_Cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] inst;
    logic [N-1:0] pc;
    logic [19:0]  imm;
    logic         imm_type;
    logic         imm_use;
  } entry_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  state_t state_reg, state_next;
  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   ready_reg, ready_next;

  entry_t idle_entry;
  entry_t in_entry;
  logic   accept;
  logic   consume;

  assign idle_entry = '{inst: NOP, pc: RESET_PC, imm: 20'h0, imm_type: 1'b0, imm_use: 1'b0};

  // Immediate is decoded from the raw fetch word so ID sees it straight from a register.
  always_comb begin
    in_entry          = idle_entry;
    in_entry.inst     = In_Inst;
    in_entry.pc       = In_PC;
    in_entry.imm      = 20'h0;
    in_entry.imm_type = 1'b0;
    in_entry.imm_use  = 1'b0;
    case (In_Inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        in_entry.imm     = In_Inst[31:12];
        in_entry.imm_use = 1'b1;
      end
      OPC_JAL: begin
        in_entry.imm      = {In_Inst[31], In_Inst[19:12], In_Inst[20], In_Inst[30:21]};
        in_entry.imm_type = 1'b1;
        in_entry.imm_use  = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept  = In_Valid & ready_reg;
  assign consume = (state_reg != S_EMPTY) & Out_Ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (Flush) begin
      state_next = S_EMPTY;
      main_next  = idle_entry;
      skid_next  = idle_entry;
    end else begin
      case (state_reg)
        S_EMPTY: begin
          if (accept) begin
            main_next  = in_entry;
            state_next = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !consume) begin
            skid_next  = in_entry;
            state_next = S_TWO;
          end else if (accept && consume) begin
            main_next = in_entry;
          end else if (consume) begin
            main_next  = idle_entry;
            state_next = S_EMPTY;
          end
        end
        S_TWO: begin
          // In_Ready is low here, so only the drain path exists.
          if (consume) begin
            main_next  = skid_reg;
            skid_next  = idle_entry;
            state_next = S_ONE;
          end
        end
        default: begin
          state_next = S_EMPTY;
          main_next  = idle_entry;
          skid_next  = idle_entry;
        end
      endcase
    end
    ready_next = (state_next != S_TWO);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= S_EMPTY;
      main_reg  <= '{inst: NOP, pc: RESET_PC, imm: 20'h0, imm_type: 1'b0, imm_use: 1'b0};
      skid_reg  <= '{inst: NOP, pc: RESET_PC, imm: 20'h0, imm_type: 1'b0, imm_use: 1'b0};
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      ready_reg <= ready_next;
    end
  end

  assign In_Ready     = ready_reg;
  assign Out_Valid    = (state_reg != S_EMPTY);
  assign Out_Inst     = main_reg.inst;
  assign Out_PC       = main_reg.pc;
  assign Out_Imm      = main_reg.imm;
  assign Out_Imm_Type = main_reg.imm_type;
  assign Out_Imm_Use  = main_reg.imm_use;

`ifdef IF_ID_PERF_EN
  // Saturating event counters; they hold at all-ones rather than wrapping.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Stall_Cnt <= 32'h0;
      Flush_Cnt <= 16'h0;
    end else begin
      if (In_Valid && !ready_reg && (Stall_Cnt != 32'hFFFF_FFFF))
        Stall_Cnt <= Stall_Cnt + 32'd1;
      if (Flush && (Flush_Cnt != 16'hFFFF))
        Flush_Cnt <= Flush_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: immediates, skid buffering, flush, async reset.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [19:0] out_imm;
  logic        out_imm_type;
  logic        out_imm_use;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_id_stage dut (
    .Clk(clk), .Rst(rst),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Inst(in_inst), .In_PC(in_pc),
    .Flush(flush),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Inst(out_inst), .Out_PC(out_pc),
    .Out_Imm(out_imm), .Out_Imm_Type(out_imm_type), .Out_Imm_Use(out_imm_use)
`ifdef IF_ID_PERF_EN
    , .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_inst: got %h want 00000013", out_inst); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== 22'h0) begin n_bad++; $display("FAIL rst_imm: got %h/%0h/%0h want 0/0/0", out_imm, out_imm_type, out_imm_use); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0h want 1", in_ready); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_imm;
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h1234_5037; in_pc = 32'h100;
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lui_valid: got %0h want 1", out_valid); end
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== {20'h12345, 1'b0, 1'b1}) begin n_bad++; $display("FAIL lui_imm: got %h/%0h/%0h want 12345/0/1", out_imm, out_imm_type, out_imm_use); end
    n_cmp++; if (out_pc !== 32'h100) begin n_bad++; $display("FAIL lui_pc: got %h want 100", out_pc); end
    in_inst = 32'h8000_006F; in_pc = 32'h104;
    cyc();
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== {20'h80000, 1'b1, 1'b1}) begin n_bad++; $display("FAIL jal_imm: got %h/%0h/%0h want 80000/1/1", out_imm, out_imm_type, out_imm_use); end
    n_cmp++; if (out_pc !== 32'h104) begin n_bad++; $display("FAIL jal_pc: got %h want 104", out_pc); end
    in_inst = 32'h00B5_0533; in_pc = 32'h108;
    cyc();
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== {20'h0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL add_imm: got %h/%0h/%0h want 0/0/0", out_imm, out_imm_type, out_imm_use); end
    n_cmp++; if (out_inst !== 32'h00B5_0533) begin n_bad++; $display("FAIL add_inst: got %h want 00b50533", out_inst); end
    in_inst = 32'h0000_1097; in_pc = 32'h10C;
    cyc();
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== {20'h00001, 1'b0, 1'b1}) begin n_bad++; $display("FAIL auipc_imm: got %h/%0h/%0h want 00001/0/1", out_imm, out_imm_type, out_imm_use); end
    in_inst = 32'h0080_006F; in_pc = 32'h110;
    cyc();
    n_cmp++; if ({out_imm, out_imm_type, out_imm_use} !== {20'h00004, 1'b1, 1'b1}) begin n_bad++; $display("FAIL jal8_imm: got %h/%0h/%0h want 00004/1/1", out_imm, out_imm_type, out_imm_use); end
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL drain_inst: got %h want 00000013", out_inst); end
    $display("test_imm done");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h0010_0093; in_pc = 32'h200;
    cyc();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_a: got %0h want 1", in_ready); end
    in_inst = 32'h0020_0113; in_pc = 32'h204;
    cyc();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_b: got %0h want 0", in_ready); end
    n_cmp++; if (out_pc !== 32'h200) begin n_bad++; $display("FAIL skid_pc_b: got %h want 200", out_pc); end
    in_inst = 32'h0030_0193; in_pc = 32'h208;
    cyc();
    n_cmp++; if ({out_valid, out_inst, out_pc} !== {1'b1, 32'h0010_0093, 32'h200}) begin n_bad++; $display("FAIL skid_hold: got %0h/%h/%h want 1/00100093/200", out_valid, out_inst, out_pc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_c: got %0h want 0", in_ready); end
    out_ready = 1'b1;
    cyc();
    n_cmp++; if ({out_valid, out_inst, out_pc} !== {1'b1, 32'h0020_0113, 32'h204}) begin n_bad++; $display("FAIL drain_b: got %0h/%h/%h want 1/00200113/204", out_valid, out_inst, out_pc); end
    cyc();
    n_cmp++; if ({out_valid, out_inst, out_pc} !== {1'b1, 32'h0030_0193, 32'h208}) begin n_bad++; $display("FAIL drain_c: got %0h/%h/%h want 1/00300193/208", out_valid, out_inst, out_pc); end
    in_valid = 1'b0;
    cyc();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL drain_empty: got valid %0h ready %0h want 0 1", out_valid, in_ready); end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h0040_0213; in_pc = 32'h300;
    cyc();
    in_inst = 32'h0050_0293; in_pc = 32'h304;
    cyc();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre_ready: got %0h want 0", in_ready); end
    flush = 1'b1; in_inst = 32'hABCD_E0B7; in_pc = 32'h308;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_inst, out_pc} !== {1'b0, 32'h0000_0013, 32'h0}) begin n_bad++; $display("FAIL flush_two: got %0h/%h/%h want 0/00000013/0", out_valid, out_inst, out_pc); end
    n_cmp++; if ({in_ready, out_imm, out_imm_use} !== {1'b1, 20'h0, 1'b0}) begin n_bad++; $display("FAIL flush_two_rdy: got %0h/%h/%0h want 1/0/0", in_ready, out_imm, out_imm_use); end
    out_ready = 1'b1;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost: got %0h want 0", out_valid); end
    // ONE state: the input accepted in the flush cycle must be dropped.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h0060_0313; in_pc = 32'h30C;
    cyc();
    flush = 1'b1; in_inst = 32'h1111_10B7; in_pc = 32'h310;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'h0}) begin n_bad++; $display("FAIL flush_one: got %0h/%0h/%h want 0/1/0", out_valid, in_ready, out_pc); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_one_ghost: got %0h want 0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h0070_0393; in_pc = 32'h400;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h400}) begin n_bad++; $display("FAIL arst_pre: got %0h/%h want 1/400", out_valid, out_pc); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, out_pc, out_inst} !== {1'b0, 32'h0, 32'h0000_0013}) begin n_bad++; $display("FAIL arst_now: got %0h/%h/%h want 0/0/00000013", out_valid, out_pc, out_inst); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %0h want 1", in_ready); end
    cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_after: got %0h want 0", out_valid); end
    $display("test_async_reset done");
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if ({stall_cnt, flush_cnt} !== 48'h0) begin n_bad++; $display("FAIL perf_rst0: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h0010_0093; in_pc = 32'h500;
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    cyc();
    flush = 1'b0;
    n_cmp++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_stall: got %0d want 3", stall_cnt); end
    n_cmp++; if (flush_cnt !== 16'd2) begin n_bad++; $display("FAIL perf_flush: got %0d want 2", flush_cnt); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({stall_cnt, flush_cnt} !== 48'h0) begin n_bad++; $display("FAIL perf_rst1: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    cyc();
    rst = 1'b0;
    $display("test_perf done");
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_imm();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef IF_ID_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
